quad_gray_decoder: RTL

Input-side counterpart to the board's Gray-code LED pattern generator. The block samples a 2-bit Gray-coded input pair, such as a quadrature rotary encoder or a loopback of two adjacent Gray-counter bits. It synchronizes and debounces the pair, decodes each legal single-bit transition into an up or down step, and keeps a wrapping position count. It sits directly behind the input pads in the fabric clock domain, i.e. the clock driven from the global clock buffer.

---
 rtl/quad_gray_decoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/quad_gray_decoder.sv
// Quadrature / 2-bit Gray input decoder: synchronizes and debounces the pin pair,
// turns legal single-bit transitions into up/down steps and keeps a wrapping count.
module quad_gray_decoder #(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] position,
  output logic             step_valid,
  output logic             step_dir,
  output logic             error
);

  localparam int            CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [1:0]       s1_q, s2_q, s2_prev_q;
  logic [1:0]       stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic             step_valid_q, step_valid_d;
  logic             step_dir_q, step_dir_d;
  logic             error_q, error_d;

  logic             accept;
  logic [1:0]       delta;

  // Gray pair {a,b} -> ring index so a single-bit move is +/-1 mod 4.
  function automatic logic [1:0] gray_idx(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  assign accept = (s2_q == s2_prev_q) && (s2_q != stable_q) && (cnt_q == CNT_MAX);
  assign delta  = gray_idx(s2_q) - gray_idx(stable_q);

  always_comb begin
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    position_d   = position_q;
    step_valid_d = 1'b0;
    step_dir_d   = step_dir_q;
    error_d      = error_q;

    if ((s2_q != s2_prev_q) || (s2_q == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      stable_d = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (accept) begin
      case (delta)
        2'd1: begin
          step_valid_d = 1'b1;
          step_dir_d   = 1'b1;
          position_d   = position_q + 1'b1;
        end
        2'd3: begin
          step_valid_d = 1'b1;
          step_dir_d   = 1'b0;
          position_d   = position_q - 1'b1;
        end
        default: ;
      endcase
    end

    // clear overrides any step on position, but an illegal jump still sets error.
    if (clear) begin
      position_d = '0;
      error_d    = 1'b0;
    end
    if (accept && (delta == 2'd2)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 2'b00;
      s2_q         <= 2'b00;
      s2_prev_q    <= 2'b00;
      stable_q     <= 2'b00;
      cnt_q        <= '0;
      position_q   <= '0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      s1_q         <= {enc_a, enc_b};
      s2_q         <= s1_q;
      s2_prev_q    <= s2_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      position_q   <= position_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      error_q      <= error_d;
    end
  end

  assign position   = position_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign error      = error_q;

endmodule
